// File: rtl/uart_rx_fifo.sv
// Receive-side character buffer behind the UART receiver: stores each character
// with its parity/framing flags and presents them first-word-fall-through.
module uart_rx_fifo #(
   parameter int DATA_BITS = 8,
   parameter int DEPTH     = 16,
   parameter int AF_LEVEL  = 12
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [DATA_BITS-1:0]         rx_data,
   input  logic                         data_ready,
   input  logic                         parity_err,
   input  logic                         frame_err,
   output logic [DATA_BITS-1:0]         out_data,
   output logic                         out_parity_err,
   output logic                         out_frame_err,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output logic                         empty,
   output logic                         full,
   output logic                         almost_full,
   output logic                         overrun,
   input  logic                         overrun_clr
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH+1);
   localparam int EW = DATA_BITS + 2;

   localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);
   localparam logic [LW-1:0] LEVEL_AF   = LW'(AF_LEVEL);

   logic [EW-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [LW-1:0] count;
   logic          overrun_q;

   logic          wr;
   logic          rd;
   logic          wr_ok;
   logic          drop;
   logic [EW-1:0] head;

   // Full/empty come from the occupancy counter, so pointer equality is never ambiguous.
   assign empty       = (count == '0);
   assign full        = (count == LEVEL_FULL);
   assign almost_full = (count >= LEVEL_AF);
   assign level       = count;
   assign overrun     = overrun_q;
   assign out_valid   = !empty;

   assign wr    = data_ready;
   assign rd    = out_valid && out_ready;
   assign wr_ok = wr && (!full || rd);
   assign drop  = wr && full && !rd;

   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wr_ptr] <= {frame_err, parity_err, rx_data};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overrun_q <= 1'b0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({wr_ok, rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         // A drop in the same cycle as a clear keeps the flag set.
         if (drop) begin
            overrun_q <= 1'b1;
         end else if (overrun_clr) begin
            overrun_q <= 1'b0;
         end
      end
   end

   always_comb begin
      head           = mem[rd_ptr];
      out_data       = '0;
      out_parity_err = 1'b0;
      out_frame_err  = 1'b0;
      if (!empty) begin
         out_data       = head[DATA_BITS-1:0];
         out_parity_err = head[DATA_BITS];
         out_frame_err  = head[DATA_BITS+1];
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: reset values, FWFT ordering with flags,
// full/almost-full/overrun behaviour, pointer wrap and mid-stream reset.
module tb_uart_rx_fifo;

   logic       clk;
   logic       reset;
   logic [7:0] rx_data;
   logic       data_ready;
   logic       parity_err;
   logic       frame_err;
   logic [7:0] out_data;
   logic       out_parity_err;
   logic       out_frame_err;
   logic       out_valid;
   logic       out_ready;
   logic [4:0] level;
   logic       empty;
   logic       full;
   logic       almost_full;
   logic       overrun;
   logic       overrun_clr;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] exp_q[$];

   uart_rx_fifo #(.DATA_BITS(8), .DEPTH(16), .AF_LEVEL(12)) dut (
      .clk(clk),
      .reset(reset),
      .rx_data(rx_data),
      .data_ready(data_ready),
      .parity_err(parity_err),
      .frame_err(frame_err),
      .out_data(out_data),
      .out_parity_err(out_parity_err),
      .out_frame_err(out_frame_err),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .level(level),
      .empty(empty),
      .full(full),
      .almost_full(almost_full),
      .overrun(overrun),
      .overrun_clr(overrun_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock, then settle 1ns past the edge before sampling or driving.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] d, input logic p, input logic f);
      data_ready = 1'b1;
      rx_data    = d;
      parity_err = p;
      frame_err  = f;
      step();
      data_ready = 1'b0;
      parity_err = 1'b0;
      frame_err  = 1'b0;
   endtask

   initial begin
      int k;
      int got;
      logic [7:0] d;

      reset = 1'b1; rx_data = '0; data_ready = 1'b0; parity_err = 1'b0;
      frame_err = 1'b0; out_ready = 1'b0; overrun_clr = 1'b0;
      step(); step();
      reset = 1'b0;
      step();

      // Reset values
      check("rst_valid", out_valid, 0);
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_af", almost_full, 0);
      check("rst_level", level, 0);
      check("rst_overrun", overrun, 0);
      check("rst_data", out_data, 0);
      check("rst_perr", out_parity_err, 0);
      check("rst_ferr", out_frame_err, 0);

      // Single write then pop
      push(8'hA5, 1'b0, 1'b0);
      check("w1_valid", out_valid, 1);
      check("w1_data", out_data, 8'hA5);
      check("w1_perr", out_parity_err, 0);
      check("w1_ferr", out_frame_err, 0);
      check("w1_level", level, 1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("pop1_empty", empty, 1);
      check("pop1_valid", out_valid, 0);
      check("pop1_data", out_data, 0);

      // Ordering with per-entry flags, back-to-back strobes
      push(8'h11, 1'b1, 1'b0);
      push(8'h22, 1'b0, 1'b0);
      push(8'h33, 1'b0, 1'b1);
      check("ord_level3", level, 3);
      out_ready = 1'b1;
      check("ord0_data", out_data, 8'h11);
      check("ord0_perr", out_parity_err, 1);
      check("ord0_ferr", out_frame_err, 0);
      step();
      check("ord_level2", level, 2);
      check("ord1_data", out_data, 8'h22);
      check("ord1_perr", out_parity_err, 0);
      check("ord1_ferr", out_frame_err, 0);
      step();
      check("ord_level1", level, 1);
      check("ord2_data", out_data, 8'h33);
      check("ord2_perr", out_parity_err, 0);
      check("ord2_ferr", out_frame_err, 1);
      step();
      check("ord_level0", level, 0);
      check("ord_empty", empty, 1);
      out_ready = 1'b0;

      // Fill to full, check almost_full / full thresholds
      for (int i = 0; i < 16; i++) begin
         push(8'(i), 1'b0, 1'b0);
         check("fill_level", level, i + 1);
         check("fill_af", almost_full, (i + 1 >= 12) ? 1 : 0);
         check("fill_full", full, (i + 1 == 16) ? 1 : 0);
      end
      check("pre_drop_overrun", overrun, 0);
      push(8'hFF, 1'b0, 1'b0);
      check("drop_overrun", overrun, 1);
      check("drop_level", level, 16);
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         check("drain_data", out_data, i);
         step();
      end
      out_ready = 1'b0;
      check("drain_empty", empty, 1);
      check("drain_data0", out_data, 0);

      overrun_clr = 1'b1;
      step();
      overrun_clr = 1'b0;
      check("clr_overrun", overrun, 0);

      // Full with simultaneous pop and write
      for (int i = 0; i < 16; i++) push(8'(i), 1'b0, 1'b0);
      check("sim_full", full, 1);
      out_ready = 1'b1;
      push(8'h55, 1'b0, 1'b0);
      out_ready = 1'b0;
      check("sim_level", level, 16);
      check("sim_overrun", overrun, 0);
      check("sim_head", out_data, 8'h01);
      out_ready = 1'b1;
      for (int i = 1; i < 16; i++) begin
         check("sim_drain", out_data, i);
         step();
      end
      check("sim_last", out_data, 8'h55);
      step();
      out_ready = 1'b0;
      check("sim_empty", empty, 1);

      // Drop racing with overrun_clr: set wins
      for (int i = 0; i < 16; i++) push(8'(8'h80 + i), 1'b0, 1'b0);
      overrun_clr = 1'b1;
      push(8'hEE, 1'b0, 1'b0);
      overrun_clr = 1'b0;
      check("race_overrun", overrun, 1);
      check("race_level", level, 16);
      overrun_clr = 1'b1;
      step();
      overrun_clr = 1'b0;
      check("race_clr", overrun, 0);
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         check("race_drain", out_data, 8'h80 + i);
         step();
      end
      out_ready = 1'b0;
      check("race_empty", empty, 1);

      // 40-character stream across pointer wrap, out_ready alternating
      k = 0;
      got = 0;
      exp_q.delete();
      for (int c = 0; c < 300 && got < 40; c++) begin
         out_ready  = c[0];
         data_ready = (k < 40) && (c % 3 != 2);
         rx_data    = 8'(8'hC0 + k);
         if (out_ready && exp_q.size() > 0) begin
            check("wrap_data", out_data, exp_q[0]);
            void'(exp_q.pop_front());
            got++;
         end else begin
            check("wrap_valid", out_valid, (exp_q.size() > 0) ? 1 : 0);
         end
         if (data_ready) begin
            exp_q.push_back(rx_data);
            k++;
         end
         step();
      end
      data_ready = 1'b0;
      out_ready  = 1'b0;
      check("wrap_count", got, 40);
      check("wrap_overrun", overrun, 0);
      check("wrap_empty", empty, 1);

      // Reset while holding 5 entries with overrun set
      for (int i = 0; i < 17; i++) push(8'(i), 1'b0, 1'b0);
      out_ready = 1'b1;
      for (int i = 0; i < 11; i++) step();
      out_ready = 1'b0;
      check("prerst_level", level, 5);
      check("prerst_overrun", overrun, 1);
      d = out_data;
      check("prerst_head", d, 8'd11);
      reset = 1'b1; data_ready = 1'b1; out_ready = 1'b1; rx_data = 8'h77;
      step();
      reset = 1'b0; data_ready = 1'b0; out_ready = 1'b0;
      check("midrst_level", level, 0);
      check("midrst_valid", out_valid, 0);
      check("midrst_overrun", overrun, 0);
      check("midrst_empty", empty, 1);
      check("midrst_data", out_data, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
